// File: rtl/matrix_mult_pkg.sv
// Shared constants and FSM state type for the 3x3 matrix multiplier.
package matrix_mult_pkg;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned RW_DEF   = 16;
  localparam int unsigned SUM_W    = 18;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned LAST_IDX = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/matrix_mult_dot3_unit.sv
// Combinational 3-term unsigned dot product with an 18-bit sum.
// Output stage saturates when MATRIX_MULT_SATURATE_EN is defined, else truncates.
module dot3_unit
  import matrix_mult_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] a2,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] b1,
  input  logic [DW-1:0] b2,
  output logic [RW-1:0] res_c
);
  localparam int unsigned PW = 2 * DW;

  logic [PW-1:0]    p0, p1, p2;
  logic [SUM_W-1:0] sum;

  always_comb begin
    p0  = PW'(a0) * PW'(b0);
    p1  = PW'(a1) * PW'(b1);
    p2  = PW'(a2) * PW'(b2);
    sum = SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2);
  end

`ifdef MATRIX_MULT_SATURATE_EN
  always_comb begin
    res_c = (|sum[SUM_W-1:RW]) ? {RW{1'b1}} : sum[RW-1:0];
  end
`else
  // Upper sum bits are intentionally dropped (modulo 2^RW result).
  logic unused_hi;
  assign unused_hi = |sum[SUM_W-1:RW];
  always_comb begin
    res_c = sum[RW-1:0];
  end
`endif
endmodule

// File: rtl/matrix_mult_top.sv
// Sequential 3x3 unsigned matrix multiplier, one result element per cycle.
// Build option: MATRIX_MULT_SATURATE_EN clamps results instead of wrapping.
module matrix_mult_top
  import matrix_mult_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a11, a12, a13, a21, a22, a23, a31, a32, a33,
  input  logic [DW-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33,
  output logic [RW-1:0] c11, c12, c13, c21, c22, c23, c31, c32, c33,
  output logic          done
);
  state_t state, state_d;
  logic             capture, wr_en, done_d;
  logic [DW-1:0]    a_q [3][3];
  logic [DW-1:0]    b_q [3][3];
  logic [IDX_W-1:0] idx;
  logic [1:0]       row, col;
  logic [RW-1:0]    res_c;

  dot3_unit #(.DW(DW), .RW(RW)) u_dot3 (
    .a0   (a_q[row][0]),
    .a1   (a_q[row][1]),
    .a2   (a_q[row][2]),
    .b0   (b_q[0][col]),
    .b1   (b_q[1][col]),
    .b2   (b_q[2][col]),
    .res_c(res_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and datapath strobes; a held start cannot retrigger because DONE waits for start low.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    wr_en   = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        wr_en = 1'b1;
        if (idx == IDX_W'(LAST_IDX)) state_d = DONE;
      end
      DONE: begin
        done_d = start;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          a_q[r][k] <= '0;
          b_q[r][k] <= '0;
        end
      end
      idx  <= '0;
      row  <= '0;
      col  <= '0;
      done <= 1'b0;
      c11 <= '0; c12 <= '0; c13 <= '0;
      c21 <= '0; c22 <= '0; c23 <= '0;
      c31 <= '0; c32 <= '0; c33 <= '0;
    end else begin
      done <= done_d;
      if (capture) begin
        a_q[0][0] <= a11; a_q[0][1] <= a12; a_q[0][2] <= a13;
        a_q[1][0] <= a21; a_q[1][1] <= a22; a_q[1][2] <= a23;
        a_q[2][0] <= a31; a_q[2][1] <= a32; a_q[2][2] <= a33;
        b_q[0][0] <= b11; b_q[0][1] <= b12; b_q[0][2] <= b13;
        b_q[1][0] <= b21; b_q[1][1] <= b22; b_q[1][2] <= b23;
        b_q[2][0] <= b31; b_q[2][1] <= b32; b_q[2][2] <= b33;
        idx <= '0;
        row <= '0;
        col <= '0;
      end
      if (wr_en) begin
        case (idx)
          4'd0: c11 <= res_c;
          4'd1: c12 <= res_c;
          4'd2: c13 <= res_c;
          4'd3: c21 <= res_c;
          4'd4: c22 <= res_c;
          4'd5: c23 <= res_c;
          4'd6: c31 <= res_c;
          4'd7: c32 <= res_c;
          4'd8: c33 <= res_c;
          default: ;
        endcase
        idx <= idx + IDX_W'(1);
        // Row/col walk row-major and wrap to 0 so the operand muxes stay in range.
        if (col == 2'd2) begin
          col <= 2'd0;
          row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
        end else begin
          col <= col + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_mult_top.sv
// Scoreboard bench for matrix_mult_top: stimulus queues expected C and done cycle, monitor checks on done rise.
module tb_matrix_mult_top;
  typedef logic [8:0][7:0]  mat8_t;
  typedef logic [8:0][15:0] mat16_t;
  typedef struct {
    mat16_t c;
    int     cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst, start, done;
  mat8_t  av, bv;
  mat16_t cv;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb [$];
  logic   done_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_mult_top dut (
    .clk(clk), .rst(rst), .start(start),
    .a11(av[0]), .a12(av[1]), .a13(av[2]), .a21(av[3]), .a22(av[4]),
    .a23(av[5]), .a31(av[6]), .a32(av[7]), .a33(av[8]),
    .b11(bv[0]), .b12(bv[1]), .b13(bv[2]), .b21(bv[3]), .b22(bv[4]),
    .b23(bv[5]), .b31(bv[6]), .b32(bv[7]), .b33(bv[8]),
    .c11(cv[0]), .c12(cv[1]), .c13(cv[2]), .c21(cv[3]), .c22(cv[4]),
    .c23(cv[5]), .c31(cv[6]), .c32(cv[7]), .c33(cv[8]),
    .done(done)
  );

  function automatic mat8_t m8(input int x0, x1, x2, x3, x4, x5, x6, x7, x8);
    m8 = {8'(x8), 8'(x7), 8'(x6), 8'(x5), 8'(x4), 8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic mat16_t m16(input int x0, x1, x2, x3, x4, x5, x6, x7, x8);
    m16 = {16'(x8), 16'(x7), 16'(x6), 16'(x5), 16'(x4), 16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  function automatic mat16_t fill16(input int v);
    for (int k = 0; k < 9; k++) fill16[k] = 16'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_c(input string name, input mat16_t exp);
    for (int k = 0; k < 9; k++) chk($sformatf("%s[c%0d%0d]", name, k / 3 + 1, k % 3 + 1), 32'(cv[k]), 32'(exp[k]));
  endtask

  // Monitor: on each done rise, pop the oldest expected result and check values and timing.
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending operation", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", 32'(cyc), 32'(e.cyc));
        chk_c("result", e.c);
      end
    end
    done_prev = done;
  end

  task automatic run_op(input mat8_t a, input mat8_t b, input mat16_t e, input bit zero_after);
    int n;
    exp_t x;
    @(negedge clk);
    av = a;
    bv = b;
    start = 1'b1;
    x.c = e;
    x.cyc = cyc + 11;
    sb.push_back(x);
    if (zero_after) begin
      @(negedge clk);
      av = '0;
      bv = '0;
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=%0b expected 1 within 40 cycles", done);
      void'(sb.pop_front());
    end
    repeat (2) @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk_c("c_retain", e);
  endtask

  initial begin
    mat8_t  a1, b1, id, all255, zero;
    mat16_t big;
    rst = 1'b1;
    start = 1'b0;
    av = '0;
    bv = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_done", 32'(done), 32'd0);
    chk_c("reset_c", '0);

    a1 = m8(1, 2, 3, 4, 5, 6, 7, 8, 9);
    b1 = m8(9, 8, 7, 6, 5, 4, 3, 2, 1);
    id = m8(1, 0, 0, 0, 1, 0, 0, 0, 1);
    all255 = m8(255, 255, 255, 255, 255, 255, 255, 255, 255);
    zero = '0;
`ifdef MATRIX_MULT_SATURATE_EN
    big = fill16(65535);
`else
    big = fill16(64003);
`endif

    run_op(a1, b1, m16(30, 24, 18, 84, 69, 54, 138, 114, 90), 1'b0);
    run_op(id, b1, m16(9, 8, 7, 6, 5, 4, 3, 2, 1), 1'b0);
    run_op(all255, all255, big, 1'b0);
    run_op(a1, b1, m16(30, 24, 18, 84, 69, 54, 138, 114, 90), 1'b1);

    // Reset in the middle of COMPUTE discards everything.
    @(negedge clk);
    av = a1;
    bv = b1;
    start = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_done", 32'(done), 32'd0);
    chk_c("midrst_c", '0);
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);

    run_op(id, b1, m16(9, 8, 7, 6, 5, 4, 3, 2, 1), 1'b0);
    run_op(zero, b1, '0, 1'b0);
    run_op(a1, zero, '0, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
